// File: rtl/pc_ctrl_pkg.sv
// Shared selection codes, FSM state encoding and counter width for the
// PC selection controller.
package pc_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    SEL_NEXT   = 2'b00,
    SEL_FIRST  = 2'b01,
    SEL_INT    = 2'b10,
    SEL_BRANCH = 2'b11
  } sel_e;

  typedef enum logic [2:0] {
    BOOT,
    RUN,
    INT_DRAIN,
    INT_SAVE,
    INT_VEC
  } state_e;

endpackage

// File: rtl/int_edge_latch.sv
// Registers int_req, detects its rising edge and holds a pending flag
// that is set on a qualified edge and cleared on request (set wins).
module int_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic int_req,
  input  logic set_en,
  input  logic clear,
  output logic pending
);

  logic int_req_q;
  logic rise;

  assign rise = int_req & ~int_req_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_req_q <= 1'b0;
      pending   <= 1'b0;
    end else begin
      int_req_q <= int_req;
      if (rise && set_en)
        pending <= 1'b1;
      else if (clear)
        pending <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_select_ctrl.sv
// PC source selection controller: boot, fetch, stall, branch redirect and
// multi-cycle interrupt entry. Define PC_CTRL_INT_MASK_EN to add rti and masking.
module pc_select_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES  = 1,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       int_req,
  input  logic       branch_taken,
  input  logic       stall,
  input  logic       mem_busy,
`ifdef PC_CTRL_INT_MASK_EN
  input  logic       rti,
`endif
  output logic [1:0] selection,
  output logic       pc_enable,
  output logic       flush_fd,
  output logic       save_pc,
  output logic       int_ack,
  output logic       busy
);

  localparam cnt_t BOOT_LAST  = cnt_t'(BOOT_CYCLES);
  localparam cnt_t DRAIN_LOAD = cnt_t'(DRAIN_CYCLES - 1);

  state_e state, state_nxt;
  cnt_t   cnt, cnt_nxt;
  logic   pending;
  logic   masked;
  logic   set_en;
  logic   clear;

  assign set_en = (state != BOOT);
  assign clear  = (state == INT_VEC);

  int_edge_latch u_int_edge_latch (
    .clk     (clk),
    .rst     (rst),
    .int_req (int_req),
    .set_en  (set_en),
    .clear   (clear),
    .pending (pending)
  );

`ifdef PC_CTRL_INT_MASK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      masked <= 1'b0;
    else if (state == INT_VEC)
      masked <= 1'b1;
    else if (state == RUN && rti)
      masked <= 1'b0;
  end
`else
  assign masked = 1'b0;
`endif

  // The RUN cycle that leaves for the drain already counts as the first
  // bubble, so the drain counter starts one below DRAIN_CYCLES.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    selection = SEL_NEXT;
    pc_enable = 1'b0;
    flush_fd  = 1'b0;
    save_pc   = 1'b0;
    int_ack   = 1'b0;
    busy      = (state != RUN);
    case (state)
      BOOT: begin
        selection = SEL_FIRST;
        flush_fd  = 1'b1;
        if (cnt == BOOT_LAST) begin
          pc_enable = 1'b1;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + cnt_t'(1);
        end
      end
      RUN: begin
        if (branch_taken) begin
          selection = SEL_BRANCH;
          pc_enable = 1'b1;
          flush_fd  = 1'b1;
        end else if (stall) begin
          pc_enable = 1'b0;
        end else if (pending && !masked) begin
          flush_fd  = 1'b1;
          cnt_nxt   = DRAIN_LOAD;
          state_nxt = (DRAIN_CYCLES == 1) ? INT_SAVE : INT_DRAIN;
        end else begin
          pc_enable = 1'b1;
        end
      end
      INT_DRAIN: begin
        flush_fd = 1'b1;
        if (branch_taken) begin
          selection = SEL_BRANCH;
          pc_enable = 1'b1;
        end
        if (!stall) begin
          if (cnt <= cnt_t'(1)) begin
            cnt_nxt   = '0;
            state_nxt = INT_SAVE;
          end else begin
            cnt_nxt = cnt - cnt_t'(1);
          end
        end
      end
      INT_SAVE: begin
        if (!mem_busy) begin
          save_pc   = 1'b1;
          state_nxt = INT_VEC;
        end
      end
      INT_VEC: begin
        selection = SEL_INT;
        pc_enable = 1'b1;
        int_ack   = 1'b1;
        flush_fd  = 1'b1;
        state_nxt = RUN;
      end
      default: begin
        state_nxt = BOOT;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule
